// File: rtl/booth_r4_pkg.sv
// Shared constants for the radix-4 Booth multiplier: FSM encoding and Booth select codes.
// Booth select codes reuse the divider's {sign, digit} quotient encoding.
package booth_r4_pkg;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ITER   = 2'b01;
    localparam logic [1:0] FINISH = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_ITER   = ITER,
        ST_FINISH = FINISH
    } state_t;

    // {neg, sel[1:0]}: sel=1 selects M, sel=2 selects 2M
    localparam logic [2:0] ZERO = 3'b000;
    localparam logic [2:0] POS1 = 3'b001;
    localparam logic [2:0] POS2 = 3'b010;
    localparam logic [2:0] NEG1 = 3'b101;
    localparam logic [2:0] NEG2 = 3'b110;

    function automatic int cnt_width(input int dw);
        return $clog2(dw / 2 + 2);
    endfunction

endpackage

// File: rtl/booth_r4_mul_if.sv
// Start/finish handshake bus of the Booth multiplier.
// BOOTH_R4_SIGNED_EN adds the mul_signed request bit.
interface booth_r4_mul_if #(
    parameter int DW = 32
);
    logic              start;
    logic [DW-1:0]     multiplicand;
    logic [DW-1:0]     multiplier;
`ifdef BOOTH_R4_SIGNED_EN
    logic              mul_signed;
`endif
    logic [2*DW-1:0]   product;
    logic              mulfinish;
    logic              busy;

    modport master (
        output start, multiplicand, multiplier,
`ifdef BOOTH_R4_SIGNED_EN
        output mul_signed,
`endif
        input  product, mulfinish, busy
    );

    modport slave (
        input  start, multiplicand, multiplier,
`ifdef BOOTH_R4_SIGNED_EN
        input  mul_signed,
`endif
        output product, mulfinish, busy
    );
endinterface

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth digit encoder: turns a 3-bit multiplier window into a signed
// partial product (0, +-M, +-2M) in DW+4 bits plus its select code.
module booth_r4_encoder
    import booth_r4_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]             mr_bits,
    input  logic [DW+1:0]          m,
    output logic signed [DW+3:0]   pp,
    output logic [2:0]             sel
);
    logic signed [DW+3:0] m1;
    logic signed [DW+3:0] m2;
    logic signed [DW+3:0] mag;

    assign m1 = {{2{m[DW+1]}}, m};
    assign m2 = m1 <<< 1;

    always_comb begin
        sel = ZERO;
        unique case (mr_bits)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
        mag = sel[1] ? m2 : (sel[0] ? m1 : '0);
        pp  = sel[2] ? -mag : mag;
    end
endmodule

// File: rtl/booth_r4_mul.sv
// Iterative radix-4 Booth multiplier, 2 multiplier bits per cycle, full 2*DW product.
// Define BOOTH_R4_SIGNED_EN to add signed (two's-complement) operation via mul_signed.
module booth_r4_mul
    import booth_r4_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_r4_mul_if.slave        bus
);
    localparam int CW = cnt_width(DW);
    localparam int W  = 2 * DW + 7;

    state_t                state_q, state_d;
    logic [DW+1:0]         m_q;
    logic [DW+2:0]         mr_q;
    logic signed [DW+3:0]  acc_q;
    logic [CW-1:0]         cnt_q;
    logic [2*DW-1:0]       product_q;

    logic                  sext;
    logic                  op_zero;
    logic                  last_iter;
    logic signed [DW+3:0]  pp;
    logic [2:0]            bsel;
    logic signed [DW+3:0]  acc_sum;
    logic [W-1:0]          shifted;

`ifdef BOOTH_R4_SIGNED_EN
    assign sext = bus.mul_signed;
`else
    assign sext = 1'b0;
`endif

    assign op_zero   = (bus.multiplicand == '0) || (bus.multiplier == '0);
    assign last_iter = (cnt_q == CW'(DW / 2));

    booth_r4_encoder #(.DW(DW)) u_enc (
        .mr_bits (mr_q[2:0]),
        .m       (m_q),
        .pp      (pp),
        .sel     (bsel)
    );

    // Zero digits leave the accumulator untouched; shift keeps the sign of acc.
    assign acc_sum = (bsel == ZERO) ? acc_q : acc_q + pp;
    assign shifted = W'($signed({acc_sum, mr_q}) >>> 2);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (bus.start) state_d = op_zero ? ST_FINISH : ST_ITER;
            ST_ITER:   if (last_iter) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q       <= '0;
            mr_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (op_zero) begin
                            product_q <= '0;
                        end else begin
                            m_q   <= {{2{sext & bus.multiplicand[DW-1]}}, bus.multiplicand};
                            mr_q  <= {{2{sext & bus.multiplier[DW-1]}}, bus.multiplier, 1'b0};
                            acc_q <= '0;
                            cnt_q <= '0;
                        end
                    end
                end
                ST_ITER: begin
                    acc_q <= shifted[W-1:DW+3];
                    mr_q  <= shifted[DW+2:0];
                    cnt_q <= cnt_q + CW'(1);
                    // Low 2*DW bits of {acc, mr[DW+2:1]} after the final shift.
                    if (last_iter) product_q <= shifted[2*DW:1];
                end
                default: ;
            endcase
        end
    end

    assign bus.product   = product_q;
    assign bus.mulfinish = (state_q == ST_FINISH);
    assign bus.busy      = (state_q == ST_ITER);
endmodule

// File: doc/booth_r4_mul.md
Name: booth_r4_mul

Overview:
- Iterative radix-4 (modified Booth) multiplier. It is the inverse-operation companion to the team's radix-4 SRT divider.
- Sits beside the divider in the CPU's M-extension execution unit and uses the same start/finish handshake style.
- Retires 2 multiplier bits per cycle and produces the full 2*DW-bit product.

Parameters:
- DW, 32, operand width; must be even and >= 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch request; sampled only in IDLE
- multiplicand  input  DW  operand A; captured on accepted start
- multiplier  input  DW  operand B; captured on accepted start
- product  output  2*DW  result; valid when mulfinish=1 and held until the next accepted start
- mulfinish  output  1  one-cycle done pulse
- busy  output  1  high in ITER state

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, all registers 0, product=0, mulfinish=0, busy=0.
- States: IDLE, ITER, FINISH.
- IDLE, start=1 with both operands nonzero:
  - Capture A zero-extended to DW+2 bits as M.
  - Load the multiplier shift register with {2'b00, B, 1'b0} (DW+3 bits).
  - Clear the accumulator (DW+4 bits, signed); clear the counter; go to ITER.
- IDLE, start=1 with either operand zero: go directly to FINISH with product=0 (zero shortcut). No ITER cycles.
- IDLE, start=0: stay in IDLE; product holds its last value.
- ITER, each cycle:
  - Booth-encode mr[2:0]: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Add the selected partial product to the accumulator.
  - Arithmetic-shift the combined {acc, mr} right by 2.
  - Increment the counter.
- Iteration count: exactly DW/2+1 (17 for DW=32). After the last iteration: go to FINISH and load product from the low 2*DW bits of {acc, mr[DW+2:1]} after the final shift.
- Latency: start accepted at edge t -> mulfinish high during cycle t+DW/2+2. With the zero shortcut -> mulfinish high during cycle t+1.
- FINISH: mulfinish=1 for exactly one cycle, then go to IDLE. start in FINISH is ignored.
- start during ITER or FINISH: ignored; the operands are not resampled.
- product changes only on the transition into FINISH; it is stable otherwise.
- Negative sign weights: -M and -2M are formed as two's complement in DW+4 bits; intermediate overflow is impossible at that width.
- Counter: ceil(log2(DW/2+2)) bits, wrap not reachable.
- rst_n asserted mid-ITER: abort immediately and apply reset values; no mulfinish pulse.

Optional Feature:
- Macro: BOOTH_R4_SIGNED_EN.
- Defined:
  - Adds input port mul_signed (1 bit), sampled on accepted start.
  - When mul_signed=1, A and B are sign-extended instead of zero-extended, and the product is the two's-complement signed 2*DW product.
  - Iteration count and latency are unchanged.
- Undefined: the port is absent; operands are always unsigned.

Decomposition:
- Shared package booth_r4_pkg:
  - State encoding localparams IDLE=2'b00, ITER=2'b01, FINISH=2'b10.
  - Booth select code localparams (ZERO, POS1, POS2, NEG1, NEG2) as a 3-bit {neg, sel[1:0]}, matching the divider's {sign, q} quotient-digit encoding.
- One sub-module, booth_r4_encoder. It is combinational and takes mr[2:0], M and the width parameter. It outputs the DW+4-bit signed partial product and the select code.
- FSM, counter and datapath registers stay in the top module.

Test Plan (DW=32):
- A=7, B=6, start one cycle -> mulfinish exactly 18 cycles after the start edge, product=64'd42, busy high for 17 cycles.
- A=B=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001.
- A=0, B=32'h1234 -> mulfinish next cycle, product=0, busy never asserts.
- Signed mode (BOOTH_R4_SIGNED_EN, mul_signed=1):
  - A=32'hFFFFFFFF, B=5 -> product=64'hFFFFFFFFFFFFFFFB.
  - A=B=32'h80000000 -> product=64'h4000000000000000.
- Start A=3, B=4, then pulse start with A=9, B=9 at ITER cycle 5 -> product=12. Second request ignored; product stays 12 until a new IDLE start.
- Reset mid-ITER (cycle 8) -> next cycle product=0, mulfinish=0, busy=0. A subsequent start with A=100, B=200 yields 20000.
